// File: rtl/pcnn_ctrl_if.sv
// Handshake and strobe bundle between the PCNN sequencer and the convolution datapath.
//   start, pix_valid, out_ready : commands and handshakes into the sequencer
//   busy, done, phase           : job status out of the sequencer
//   pix_ready, out_valid        : input-beat / output-result handshake halves
//   clr .. sftcclr              : datapath clears
//   mull, addl, resultl, outl   : datapath register loads
//   rl, cl, sftrl, sftcl        : datapath counter increments
//   l, fl                       : image / filter memory write enables
// modport master is the sequencer side, modport slave the datapath/host side.
interface pcnn_ctrl_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [2:0] phase;
    logic       pix_valid;
    logic       pix_ready;
    logic       out_valid;
    logic       out_ready;
    logic       clr;
    logic       rclr;
    logic       cclr;
    logic       sftrclr;
    logic       sftcclr;
    logic       mull;
    logic       addl;
    logic       resultl;
    logic       outl;
    logic       rl;
    logic       cl;
    logic       sftrl;
    logic       sftcl;
    logic       l;
    logic       fl;

    modport master (
        input  start, pix_valid, out_ready,
        output busy, done, phase, pix_ready, out_valid,
        output clr, rclr, cclr, sftrclr, sftcclr,
        output mull, addl, resultl, outl,
        output rl, cl, sftrl, sftcl, l, fl
    );

    modport slave (
        output start, pix_valid, out_ready,
        input  busy, done, phase, pix_ready, out_valid,
        input  clr, rclr, cclr, sftrclr, sftcclr,
        input  mull, addl, resultl, outl,
        input  rl, cl, sftrl, sftcl, l, fl
    );
endinterface

// File: rtl/pcnn_ctrl.sv
// Sequencing FSM for the PCNN convolution datapath.
// Loads an As x As image and an Fs x Fs filter, runs the multiply-accumulate loop over
// every output window, then drains the Os x Os results through a valid/ready handshake.
// The datapath r, c, sftr and sftc counters are mirrored here, so every strobe is a pure
// decode of state, mirrored counters and handshake inputs.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus_io : pcnn_ctrl_if master modport (commands, handshakes, datapath strobes)
module pcnn_ctrl #(
    parameter int unsigned As  = 6,
    parameter int unsigned Fs  = 3,
    parameter int unsigned Str = 1,
    parameter int unsigned Zp  = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    pcnn_ctrl_if.master bus_io
);

    localparam int unsigned Os   = ((As + 2 * Zp - Fs) / Str) + 1;
    localparam int unsigned MaxA = (As > Fs) ? As : Fs;
    localparam int unsigned MaxN = (MaxA > Os) ? MaxA : Os;
    localparam int unsigned CntW = (MaxN > 1) ? $clog2(MaxN) : 1;

    localparam logic [CntW-1:0] AsLast = CntW'(As - 1);
    localparam logic [CntW-1:0] FsLast = CntW'(Fs - 1);
    localparam logic [CntW-1:0] OsLast = CntW'(Os - 1);

    if (Zp != 0) begin : gen_zp_unsupported
        $error("pcnn_ctrl: zero padding is not supported in this revision");
    end

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StLda,
        StLdf,
        StClr,
        StMul,
        StAdd,
        StWr,
        StOld,
        StOvld,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] r_q, r_d;
    logic [CntW-1:0] c_q, c_d;
    logic [CntW-1:0] sftr_q, sftr_d;
    logic [CntW-1:0] sftc_q, sftc_d;

    logic       busy, done, pix_ready, out_valid;
    logic [2:0] phase;
    logic       clr, rclr, cclr, sftrclr, sftcclr;
    logic       mull, addl, resultl, outl;
    logic       rl, cl, sftrl, sftcl, l, fl;
    logic [4:0] step;

    // One row-major step over an n x n grid held in (r, c).
    // Returns {rclr, cclr, rl, cl, last}; last marks the step off the final cell.
    function automatic logic [4:0] step_rc(input logic [CntW-1:0] r,
                                           input logic [CntW-1:0] c,
                                           input logic [CntW-1:0] last_idx);
        logic [4:0] s;
        s = '0;
        if (c != last_idx) begin
            s[1] = 1'b1;
        end else if (r != last_idx) begin
            s[3] = 1'b1;
            s[2] = 1'b1;
        end else begin
            s[4] = 1'b1;
            s[3] = 1'b1;
            s[0] = 1'b1;
        end
        return s;
    endfunction

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        pix_ready = 1'b0;
        out_valid = 1'b0;
        phase     = 3'd0;
        clr       = 1'b0;
        rclr      = 1'b0;
        cclr      = 1'b0;
        sftrclr   = 1'b0;
        sftcclr   = 1'b0;
        mull      = 1'b0;
        addl      = 1'b0;
        resultl   = 1'b0;
        outl      = 1'b0;
        rl        = 1'b0;
        cl        = 1'b0;
        sftrl     = 1'b0;
        sftcl     = 1'b0;
        l         = 1'b0;
        fl        = 1'b0;
        step      = '0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StInit;
                end
            end
            StInit: begin
                phase   = 3'd1;
                clr     = 1'b1;
                rclr    = 1'b1;
                cclr    = 1'b1;
                sftrclr = 1'b1;
                sftcclr = 1'b1;
                state_d = StLda;
            end
            StLda: begin
                phase     = 3'd1;
                pix_ready = 1'b1;
                if (bus_io.pix_valid) begin
                    l                     = 1'b1;
                    step                  = step_rc(r_q, c_q, AsLast);
                    {rclr, cclr, rl, cl}  = step[4:1];
                    if (step[0]) begin
                        state_d = StLdf;
                    end
                end
            end
            StLdf: begin
                phase     = 3'd2;
                pix_ready = 1'b1;
                if (bus_io.pix_valid) begin
                    fl                    = 1'b1;
                    step                  = step_rc(r_q, c_q, FsLast);
                    {rclr, cclr, rl, cl}  = step[4:1];
                    if (step[0]) begin
                        state_d = StClr;
                    end
                end
            end
            StClr: begin
                phase   = 3'd3;
                clr     = 1'b1;
                state_d = StMul;
            end
            StMul: begin
                phase   = 3'd3;
                mull    = 1'b1;
                state_d = StAdd;
            end
            StAdd: begin
                phase                 = 3'd3;
                addl                  = 1'b1;
                step                  = step_rc(r_q, c_q, FsLast);
                {rclr, cclr, rl, cl}  = step[4:1];
                state_d               = step[0] ? StWr : StMul;
            end
            StWr: begin
                phase   = 3'd3;
                resultl = 1'b1;
                state_d = StClr;
                if (sftc_q != OsLast) begin
                    sftcl = 1'b1;
                end else if (sftr_q != OsLast) begin
                    sftcclr = 1'b1;
                    sftrl   = 1'b1;
                end else begin
                    sftrclr = 1'b1;
                    sftcclr = 1'b1;
                    state_d = StOld;
                end
            end
            StOld: begin
                // r, c index the result array here; they were cleared after the last tap.
                phase   = 3'd4;
                outl    = 1'b1;
                state_d = StOvld;
            end
            StOvld: begin
                phase     = 3'd4;
                out_valid = 1'b1;
                if (bus_io.out_ready) begin
                    step                  = step_rc(r_q, c_q, OsLast);
                    {rclr, cclr, rl, cl}  = step[4:1];
                    state_d               = step[0] ? StDone : StOld;
                end
            end
            StDone: begin
                phase   = 3'd4;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Mirror of the datapath counters: the same strobes that drive the datapath update them.
    always_comb begin
        r_d = r_q;
        if (rclr) begin
            r_d = '0;
        end else if (rl) begin
            r_d = r_q + CntW'(1);
        end
        c_d = c_q;
        if (cclr) begin
            c_d = '0;
        end else if (cl) begin
            c_d = c_q + CntW'(1);
        end
        sftr_d = sftr_q;
        if (sftrclr) begin
            sftr_d = '0;
        end else if (sftrl) begin
            sftr_d = sftr_q + CntW'(1);
        end
        sftc_d = sftc_q;
        if (sftcclr) begin
            sftc_d = '0;
        end else if (sftcl) begin
            sftc_d = sftc_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            r_q     <= '0;
            c_q     <= '0;
            sftr_q  <= '0;
            sftc_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            sftr_q  <= sftr_d;
            sftc_q  <= sftc_d;
        end
    end

    assign bus_io.busy      = busy;
    assign bus_io.done      = done;
    assign bus_io.phase     = phase;
    assign bus_io.pix_ready = pix_ready;
    assign bus_io.out_valid = out_valid;
    assign bus_io.clr       = clr;
    assign bus_io.rclr      = rclr;
    assign bus_io.cclr      = cclr;
    assign bus_io.sftrclr   = sftrclr;
    assign bus_io.sftcclr   = sftcclr;
    assign bus_io.mull      = mull;
    assign bus_io.addl      = addl;
    assign bus_io.resultl   = resultl;
    assign bus_io.outl      = outl;
    assign bus_io.rl        = rl;
    assign bus_io.cl        = cl;
    assign bus_io.sftrl     = sftrl;
    assign bus_io.sftcl     = sftcl;
    assign bus_io.l         = l;
    assign bus_io.fl        = fl;

endmodule

// File: tb/tb_pcnn_ctrl.sv
// Self-checking bench for pcnn_ctrl: a behavioural datapath driven by the DUT strobes
// produces results that are compared with a direct convolution of the source arrays, and a
// job-level timeline model (beats, compute cycles, deliveries) checks every output each cycle.
module tb_pcnn_ctrl;
    localparam int AS   = 6;
    localparam int FS   = 3;
    localparam int STR  = 1;
    localparam int OS   = ((AS - FS) / STR) + 1;
    localparam int WIN  = 2 + 2 * FS * FS;
    localparam int COMP = OS * OS * WIN;
    localparam int NA   = AS * AS;
    localparam int NF   = FS * FS;
    localparam int NO   = OS * OS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pcnn_ctrl_if u_if ();

    pcnn_ctrl #(.As(AS), .Fs(FS), .Str(STR), .Zp(0)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (u_if.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int img_src[NA];
    int flt_src[NF];
    int exp_q[$];
    int got_q[$];

    // behavioural datapath
    int dp_r = 0, dp_c = 0, dp_sr = 0, dp_sc = 0;
    int img_m[NA];
    int flt_m[NF];
    int res_m[NO];
    int prod = 0, acc = 0, dp_out = 0, a_idx = 0, f_idx = 0;

    // job timeline model
    bit m_active = 0, m_init = 0, m_old = 0;
    int m_ba = 0, m_bf = 0, m_comp = 0, m_deliv = 0, m_cyc = 0, mph = 0;

    int l_cnt = 0, fl_cnt = 0, done_cnt = 0, first_ov = -1, hold_cnt = 0;
    bit job_done = 0;
    int pv_mode = 0, or_mode = 0, stall_n = 0, stall_val = 0;
    bit spur_en = 0;
    int cph, ck;
    bit e_pr;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_phase();
        if (!m_active) return 0;
        if (m_ba < NA) return 1;
        if (m_bf < NF) return 2;
        if (m_comp < COMP) return 3;
        return 4;
    endfunction

    function automatic logic [14:0] strobes();
        return {u_if.clr, u_if.rclr, u_if.cclr, u_if.sftrclr, u_if.sftcclr, u_if.mull,
                u_if.addl, u_if.resultl, u_if.outl, u_if.rl, u_if.cl, u_if.sftrl,
                u_if.sftcl, u_if.l, u_if.fl};
    endfunction

    function automatic logic [7:0] cnt_strobes();
        return {u_if.rclr, u_if.cclr, u_if.sftrclr, u_if.sftcclr,
                u_if.rl, u_if.cl, u_if.sftrl, u_if.sftcl};
    endfunction

    // Datapath emulation and timeline model, both from pre-edge values.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_init   = 0;
            m_old    = 0;
        end else begin
            mph = exp_phase();
            if (u_if.out_valid && u_if.out_ready) got_q.push_back(dp_out);
            if (u_if.l) begin
                l_cnt++;
                if (dp_r < AS && dp_c < AS && a_idx < NA) img_m[dp_r*AS+dp_c] = img_src[a_idx];
                a_idx++;
            end
            if (u_if.fl) begin
                fl_cnt++;
                if (dp_r < FS && dp_c < FS && f_idx < NF) flt_m[dp_r*FS+dp_c] = flt_src[f_idx];
                f_idx++;
            end
            if (u_if.mull) begin
                if (dp_r < FS && dp_c < FS && dp_sr*STR + dp_r < AS && dp_sc*STR + dp_c < AS)
                    prod = img_m[(dp_sr*STR+dp_r)*AS + dp_sc*STR+dp_c] * flt_m[dp_r*FS+dp_c];
                else
                    prod = -1000;
            end
            if (u_if.addl) acc = acc + prod;
            if (u_if.clr) acc = 0;
            if (u_if.resultl && dp_sr < OS && dp_sc < OS) res_m[dp_sr*OS+dp_sc] = acc;
            if (u_if.outl) dp_out = (dp_r < OS && dp_c < OS) ? res_m[dp_r*OS+dp_c] : -1;
            dp_r  = u_if.rclr    ? 0 : (u_if.rl    ? dp_r + 1  : dp_r);
            dp_c  = u_if.cclr    ? 0 : (u_if.cl    ? dp_c + 1  : dp_c);
            dp_sr = u_if.sftrclr ? 0 : (u_if.sftrl ? dp_sr + 1 : dp_sr);
            dp_sc = u_if.sftcclr ? 0 : (u_if.sftcl ? dp_sc + 1 : dp_sc);

            if (!m_active) begin
                if (u_if.start) begin
                    m_active = 1; m_init = 1; m_old = 0;
                    m_ba = 0; m_bf = 0; m_comp = 0; m_deliv = 0; m_cyc = 0;
                end
            end else begin
                m_cyc++;
                if (mph == 4 && m_deliv == NO) begin
                    m_active = 0;
                end else begin
                    case (mph)
                        1: if (!m_init && u_if.pix_valid) m_ba++;
                        2: if (u_if.pix_valid) m_bf++;
                        3: begin
                            m_comp++;
                            if (m_comp == COMP) m_old = 1;
                        end
                        default: begin
                            if (m_old) m_old = 0;
                            else if (u_if.out_ready) begin
                                m_deliv++;
                                m_old = (m_deliv < NO);
                            end
                        end
                    endcase
                    m_init = 0;
                end
            end
        end
    end

    // Per-cycle compare of every output against the timeline model.
    always @(negedge clk) begin
        cph  = exp_phase();
        ck   = m_comp % WIN;
        e_pr = (cph == 1 && !m_init) || cph == 2;
        chk("phase", u_if.phase, cph);
        chk("busy", u_if.busy, m_active);
        chk("pix_ready", u_if.pix_ready, e_pr);
        chk("l", u_if.l, cph == 1 && e_pr && u_if.pix_valid);
        chk("fl", u_if.fl, cph == 2 && u_if.pix_valid);
        chk("clr", u_if.clr, m_init || (cph == 3 && ck == 0));
        chk("mull", u_if.mull, cph == 3 && ck % 2 == 1 && ck < WIN - 1);
        chk("addl", u_if.addl, cph == 3 && ck % 2 == 0 && ck > 0 && ck < WIN - 1);
        chk("resultl", u_if.resultl, cph == 3 && ck == WIN - 1);
        chk("outl", u_if.outl, cph == 4 && m_old);
        chk("out_valid", u_if.out_valid, cph == 4 && !m_old && m_deliv < NO);
        chk("done", u_if.done, cph == 4 && m_deliv == NO);
        if (m_init) chk("init_cnt_strobes", cnt_strobes(), 8'hF0);
        else if (!m_active) chk("idle_cnt_strobes", cnt_strobes(), 0);
        if (u_if.out_valid && first_ov < 0 && m_active) first_ov = m_cyc;
        if (u_if.done) begin
            done_cnt++;
            job_done = 1;
        end
        if (or_mode == 3 && u_if.out_valid && !u_if.out_ready) hold_cnt++;
    end

    // Input drivers, changed 1 time unit after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (pv_mode)
                0:       u_if.pix_valid = 1'b1;
                1:       u_if.pix_valid = ~u_if.pix_valid;
                default: u_if.pix_valid = ($urandom_range(0, 3) != 0);
            endcase
            case (or_mode)
                0: u_if.out_ready = 1'b1;
                3: begin
                    if (u_if.out_valid && m_deliv == 2 && stall_n < 5) begin
                        if (stall_n == 0) stall_val = dp_out;
                        stall_n++;
                        u_if.out_ready = 1'b0;
                    end else begin
                        u_if.out_ready = 1'b1;
                    end
                end
                default: u_if.out_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    task automatic fill_ones();
        foreach (img_src[i]) img_src[i] = 1;
        foreach (flt_src[i]) flt_src[i] = 1;
    endtask

    task automatic fill_ident();
        foreach (img_src[i]) img_src[i] = 10 * (i / AS) + (i % AS);
        foreach (flt_src[i]) flt_src[i] = (i == (FS / 2) * FS + FS / 2) ? 1 : 0;
    endtask

    task automatic fill_rand();
        foreach (img_src[i]) img_src[i] = int'($urandom_range(0, 15));
        foreach (flt_src[i]) flt_src[i] = int'($urandom_range(0, 15));
    endtask

    task automatic build_expected();
        int s;
        exp_q.delete();
        for (int i = 0; i < OS; i++) begin
            for (int j = 0; j < OS; j++) begin
                s = 0;
                for (int u = 0; u < FS; u++)
                    for (int v = 0; v < FS; v++)
                        s += img_src[(i*STR+u)*AS + j*STR+v] * flt_src[u*FS+v];
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic start_job();
        build_expected();
        got_q.delete();
        l_cnt = 0; fl_cnt = 0; done_cnt = 0; first_ov = -1; job_done = 0;
        hold_cnt = 0; stall_n = 0; a_idx = 0; f_idx = 0;
        @(posedge clk); #1 u_if.start = 1'b1;
        @(posedge clk); #1 u_if.start = 1'b0;
    endtask

    task automatic wait_job_end();
        int i;
        i = 0;
        while (!job_done && i < 5000) begin
            @(posedge clk);
            #1;
            if (spur_en && m_active && exp_phase() != 4)
                u_if.start = ($urandom_range(0, 7) == 0);
            else
                u_if.start = 1'b0;
            i++;
        end
        u_if.start = 1'b0;
        if (!job_done) chk("job_timeout", 0, 1);
        chk("result_count", got_q.size(), NO);
        for (int k = 0; k < got_q.size() && k < NO; k++)
            chk($sformatf("result[%0d]", k), got_q[k], exp_q[k]);
        chk("done_pulses", done_cnt, 1);
        @(negedge clk);
        chk("busy_after_done", u_if.busy, 0);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_phase"}, u_if.phase, 0);
        chk({tag, "_busy"}, u_if.busy, 0);
        chk({tag, "_done"}, u_if.done, 0);
        chk({tag, "_out_valid"}, u_if.out_valid, 0);
        chk({tag, "_pix_ready"}, u_if.pix_ready, 0);
        chk({tag, "_strobes"}, strobes(), 0);
    endtask

    initial begin
        u_if.start     = 1'b0;
        u_if.pix_valid = 1'b0;
        u_if.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");

        // all-ones job, no stalls
        fill_ones();
        pv_mode = 0; or_mode = 0;
        start_job();
        wait_job_end();
        chk("first_valid_latency", first_ov, 367);
        for (int k = 0; k < got_q.size(); k++) chk("ones_value", got_q[k], 9);

        // identity filter
        fill_ident();
        start_job();
        wait_job_end();
        for (int k = 0; k < got_q.size(); k++)
            chk($sformatf("ident[%0d]", k), got_q[k], 10 * (k / OS + 1) + (k % OS) + 1);

        // input stalls
        pv_mode = 1;
        start_job();
        wait_job_end();
        chk("l_pulses", l_cnt, 36);
        chk("fl_pulses", fl_cnt, 9);
        for (int k = 0; k < got_q.size(); k++)
            chk($sformatf("stall_ident[%0d]", k), got_q[k], 10 * (k / OS + 1) + (k % OS) + 1);

        // output backpressure on the third result
        pv_mode = 0; or_mode = 3;
        start_job();
        wait_job_end();
        chk("hold_cycles", hold_cnt, 5);
        chk("stalled_value", stall_val, 13);
        if (got_q.size() > 2) chk("accepted_value", got_q[2], stall_val);

        // reset during window 7
        fill_ones();
        or_mode = 0;
        start_job();
        for (int i = 0; i < 2000 && m_comp < 6 * WIN + 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_window7", m_comp, 6 * WIN + 5);
        #2 rst_n = 1'b0;
        #1 check_quiet("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");
        start_job();
        wait_job_end();
        for (int k = 0; k < got_q.size(); k++) chk("after_reset_ones", got_q[k], 9);

        // randomized jobs with random handshakes and ignored start pulses
        pv_mode = 2; or_mode = 2; spur_en = 1;
        for (int j = 0; j < 3; j++) begin
            fill_rand();
            start_job();
            wait_job_end();
        end
        spur_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
